// File: rtl/apb_arbiter_if.sv
// Request/response channels and APB master bus for apb_arbiter.
// master = arbiter side, slave = requesters plus APB completer side.
interface apb_arbiter_if #(
  parameter int NumReq    = 2,
  parameter int AddrWidth = 8,
  parameter int DataWidth = 32
);
  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq-1:0]           req_ready_o;
  logic [NumReq*AddrWidth-1:0] req_addr_i;
  logic [NumReq-1:0]           req_write_i;
  logic [NumReq*DataWidth-1:0] req_wdata_i;
  logic [NumReq-1:0]           rsp_valid_o;
  logic [DataWidth-1:0]        rsp_rdata_o;
  logic                        rsp_err_o;
  logic                        psel_o;
  logic                        penable_o;
  logic [AddrWidth-1:0]        paddr_o;
  logic                        pwrite_o;
  logic [DataWidth-1:0]        pwdata_o;
  logic [DataWidth-1:0]        prdata_i;
  logic                        pready_i;

  modport master (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, prdata_i, pready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i, prdata_i, pready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
  );
endinterface

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB completer between NumReq requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TimeoutCycles wait states.
module apb_arbiter #(
  parameter int NumReq        = 2,
  parameter int AddrWidth     = 8,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input logic           clk_i,
  input logic           arst_ni,
  apb_arbiter_if.master bus
);
  localparam int IdxW = $clog2(NumReq);

  if (NumReq < 2 || TimeoutCycles < 1) begin : g_cfg_check
    $error("apb_arbiter: NumReq must be >= 2 and TimeoutCycles >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       last_q, last_d, win;
  logic                  any_valid;
  logic [NumReq-1:0]     grant, rsp_valid_q, rsp_valid_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            err_q, err_d;
  assign cnt_inc = cnt_q + CntW'(1);
`endif

  // Scan from farthest to nearest so the last hit is the first valid after last_q.
  always_comb begin : rr_pick
    win       = last_q;
    any_valid = 1'b0;
    for (int k = NumReq; k >= 1; k--) begin
      int idx;
      idx = int'(last_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (bus.req_valid_i[idx]) begin
        win       = IdxW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  assign grant = NumReq'(1) << win;

  always_comb begin : fsm_next
    state_d     = state_q;
    last_d      = last_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    bus.req_ready_o = '0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          bus.req_ready_o = grant;
          last_d  = win;
          addr_d  = bus.req_addr_i[int'(win)*AddrWidth +: AddrWidth];
          write_d = bus.req_write_i[win];
          wdata_d = bus.req_wdata_i[int'(win)*DataWidth +: DataWidth];
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ACCESS: begin
        // pready_i is only looked at here, so X/Z outside ACCESS is harmless.
        if (bus.pready_i) begin
          state_d     = IDLE;
          rsp_valid_d = NumReq'(1) << last_q;
          rdata_d     = write_q ? '0 : bus.prdata_i;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_inc == CntW'(TimeoutCycles)) begin
          state_d     = IDLE;
          rsp_valid_d = NumReq'(1) << last_q;
          rdata_d     = '0;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= IDLE;
      last_q      <= IdxW'(NumReq - 1);
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.psel_o      = (state_q != IDLE);
  assign bus.penable_o   = (state_q == ACCESS);
  assign bus.paddr_o     = addr_q;
  assign bus.pwrite_o    = write_q;
  assign bus.pwdata_o    = wdata_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
  assign bus.rsp_err_o   = err_q;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif
endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: vector table, corner-case sequences and random traffic
// against a transaction-level model with a small APB memory completer.
module tb_apb_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk    = 1'b0;
  logic arst_n = 1'b1;
  always #5 clk = ~clk;

  apb_arbiter_if #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) bus();

  apb_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
    .clk_i  (clk),
    .arst_ni(arst_n),
    .bus    (bus)
  );

  typedef struct {
    int              id;
    bit              wr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    int              wt;
    int              rsp_cyc;
    logic [DW-1:0]   rdata;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int t     = 0;

  logic [N-1:0]         rq_valid = '0;
  logic [N-1:0]         rq_write = '0;
  logic [N-1:0][AW-1:0] rq_addr  = '0;
  logic [N-1:0][DW-1:0] rq_wdata = '0;

  logic [DW-1:0] cmp_mem [256];
  logic [DW-1:0] ref_mem [256];
  int acc_cnt   = 0;
  int cur_wait  = 0;
  int force_wait = -1;

  // transaction-level model of the arbiter
  bit            m_active;
  bit            m_to;
  int            m_g, m_end, m_cur, m_last, m_wait;
  logic [AW-1:0] m_addr;
  logic          m_write;
  logic [DW-1:0] m_wdata, m_hold;

  logic [N-1:0]  obs_ready, obs_rsp;
  logic [DW-1:0] obs_rdata;
  logic          obs_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, t);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_last   = N - 1;
    m_addr   = '0;
    m_write  = 1'b0;
    m_wdata  = '0;
    m_hold   = '0;
    m_to     = 1'b0;
  endtask

  task automatic new_payload(input int i);
    rq_addr[i]  = AW'($urandom_range(0, 15));
    rq_write[i] = 1'($urandom_range(0, 1));
    rq_wdata[i] = $urandom;
  endtask

  // One clock cycle: drive requests, play the completer, check against the model.
  task automatic step();
    int age;
    logic exp_psel, exp_pen, exp_err;
    logic [N-1:0] exp_rsp, exp_ready;
    bit found;
    bus.req_valid_i = rq_valid;
    bus.req_write_i = rq_write;
    bus.req_addr_i  = rq_addr;
    bus.req_wdata_i = rq_wdata;
    #1;
    if (bus.psel_o && bus.penable_o) begin
      bus.pready_i = (acc_cnt == cur_wait);
      bus.prdata_i = cmp_mem[bus.paddr_o];
      if (bus.pready_i) begin
        if (bus.pwrite_o) cmp_mem[bus.paddr_o] = bus.pwdata_o;
        acc_cnt = 0;
      end else acc_cnt++;
    end else begin
      bus.pready_i = 1'($urandom_range(0, 1));
      bus.prdata_i = $urandom;
      acc_cnt = 0;
    end

    exp_psel = 1'b0; exp_pen = 1'b0; exp_err = 1'b0; exp_rsp = '0;
    if (m_active) begin
      age = t - m_g;
      exp_psel = (age >= 1) && (age < m_end);
      exp_pen  = (age >= 2) && (age < m_end);
      if (age == m_end) begin
        exp_rsp[m_cur] = 1'b1;
        exp_err = m_to;
        if (m_to) m_hold = '0;
        else if (m_write) begin ref_mem[m_addr] = m_wdata; m_hold = '0; end
        else m_hold = ref_mem[m_addr];
        m_active = 1'b0;
      end
    end
    chk("psel",      64'(bus.psel_o),      64'(exp_psel));
    chk("penable",   64'(bus.penable_o),   64'(exp_pen));
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_rsp));
    chk("rsp_err",   64'(bus.rsp_err_o),   64'(exp_err));
    chk("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(m_hold));
    chk("paddr",     64'(bus.paddr_o),     64'(m_addr));
    chk("pwrite",    64'(bus.pwrite_o),    64'(m_write));
    chk("pwdata",    64'(bus.pwdata_o),    64'(m_wdata));

    exp_ready = '0;
    found = 1'b0;
    if (!m_active) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (!found && rq_valid[i]) begin
          found = 1'b1;
          exp_ready[i] = 1'b1;
          m_cur = i; m_last = i; m_active = 1'b1; m_g = t;
`ifdef APB_ARB_TIMEOUT_EN
          m_wait = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 6));
          m_to   = (m_wait >= TO);
`else
          m_wait = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
          m_to   = 1'b0;
`endif
          cur_wait = m_wait;
          m_end    = m_to ? 2 + TO : 3 + m_wait;
          m_addr   = rq_addr[i];
          m_write  = rq_write[i];
          m_wdata  = rq_wdata[i];
        end
      end
    end
    chk("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));

    obs_ready = bus.req_ready_o;
    obs_rsp   = bus.rsp_valid_o;
    obs_rdata = bus.rsp_rdata_o;
    obs_err   = bus.rsp_err_o;
    @(negedge clk);
    t++;
  endtask

  task automatic do_reset(input int cycles);
    arst_n = 1'b0;
    rq_valid = '0;
    bus.req_valid_i = '0;
    bus.pready_i = 1'b0;
    acc_cnt = 0;
    obs_ready = '0;
    #1;
    chk("rst psel",      64'(bus.psel_o),      64'd0);
    chk("rst penable",   64'(bus.penable_o),   64'd0);
    chk("rst rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst rsp_err",   64'(bus.rsp_err_o),   64'd0);
    chk("rst rdata",     64'(bus.rsp_rdata_o), 64'd0);
    chk("rst paddr",     64'(bus.paddr_o),     64'd0);
    chk("rst pwrite",    64'(bus.pwrite_o),    64'd0);
    chk("rst pwdata",    64'(bus.pwdata_o),    64'd0);
    chk("rst req_ready", 64'(bus.req_ready_o), 64'd0);
    repeat (cycles) @(negedge clk);
    chk("rst hold rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    arst_n = 1'b1;
    model_reset();
  endtask

  task automatic req_update(input bit persist);
    for (int i = 0; i < N; i++) begin
      if (rq_valid[i] && obs_ready[i]) begin
        if (persist) new_payload(i);
        else rq_valid[i] = 1'b0;
      end else if (!persist) begin
        if (!rq_valid[i] && $urandom_range(0, 3) == 0) begin
          new_payload(i);
          rq_valid[i] = 1'b1;
        end else if (rq_valid[i] && $urandom_range(0, 31) == 0) begin
          rq_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    rq_valid = '0;
    repeat (12) step();
  endtask

  task automatic run_vec(input vec_t v);
    int got_rdy, got_rsp;
    logic [DW-1:0] got_rd;
    got_rdy = -1; got_rsp = -1; got_rd = '0;
    force_wait = v.wt;
    rq_valid = '0;
    rq_addr[v.id]  = v.addr;
    rq_write[v.id] = v.wr;
    rq_wdata[v.id] = v.wdata;
    rq_valid[v.id] = 1'b1;
    for (int c = 0; c < 20 && got_rsp < 0; c++) begin
      step();
      if (obs_ready[v.id] && got_rdy < 0) begin got_rdy = c; rq_valid[v.id] = 1'b0; end
      if (obs_rsp[v.id]) begin got_rsp = c; got_rd = obs_rdata; end
    end
    chk("vec grant cycle", 64'(got_rdy), 64'd0);
    chk("vec rsp cycle",   64'(got_rsp), 64'(v.rsp_cyc));
    chk("vec rdata",       64'(got_rd),  64'(v.rdata));
  endtask

  initial begin
    vec_t tbl [9];
    int order [8];
    int nord, got;
    logic e;
    logic [DW-1:0] d;

    tbl[0] = '{0, 1'b1, 8'h10, 32'hA5A5_0001, 0, 3, 32'h0};
    tbl[1] = '{0, 1'b0, 8'h10, 32'h0,         0, 3, 32'hA5A5_0001};
    tbl[2] = '{1, 1'b1, 8'h20, 32'h1234_5678, 3, 6, 32'h0};
    tbl[3] = '{1, 1'b0, 8'h20, 32'h0,         3, 6, 32'h1234_5678};
    tbl[4] = '{3, 1'b0, 8'h10, 32'h0,         1, 4, 32'hA5A5_0001};
    tbl[5] = '{2, 1'b1, 8'hFF, 32'hFFFF_FFFF, 2, 5, 32'h0};
    tbl[6] = '{2, 1'b0, 8'hFF, 32'h0,         0, 3, 32'hFFFF_FFFF};
    tbl[7] = '{0, 1'b1, 8'h00, 32'h0,         0, 3, 32'h0};
    tbl[8] = '{0, 1'b0, 8'h00, 32'h0,         0, 3, 32'h0};

    for (int i = 0; i < 256; i++) begin
      cmp_mem[i] = $urandom;
      ref_mem[i] = cmp_mem[i];
    end
    bus.req_valid_i = '0; bus.req_addr_i = '0; bus.req_write_i = '0;
    bus.req_wdata_i = '0; bus.prdata_i = '0; bus.pready_i = 1'b0;
    model_reset();
    #2;
    do_reset(3);

    foreach (tbl[i]) run_vec(tbl[i]);
    force_wait = -1;

    // fairness: all requesters valid continuously from reset
    do_reset(2);
    for (int i = 0; i < N; i++) begin new_payload(i); rq_valid[i] = 1'b1; end
    nord = 0;
    for (int c = 0; c < 100 && nord < 8; c++) begin
      step();
      for (int i = 0; i < N; i++) if (obs_ready[i] && nord < 8) begin order[nord] = i; nord++; end
      req_update(1'b1);
    end
    chk("rr grant count", 64'(nord), 64'd8);
    for (int k = 0; k < 8; k++) chk("rr grant order", 64'(order[k]), 64'(k % N));
    drain();

    // request arriving in the completing ACCESS cycle of another requester
    force_wait = 0;
    new_payload(0); rq_valid[0] = 1'b1;
    step();
    chk("sim grant0", 64'(obs_ready), 64'h1);
    rq_valid[0] = 1'b0;
    step();
    new_payload(1); rq_valid[1] = 1'b1;
    step();
    step();
    chk("sim grant1", 64'(obs_ready), 64'h2);
    chk("sim rsp0",   64'(obs_rsp),   64'h1);
    rq_valid[1] = 1'b0;
    drain();

    // reset while stuck in ACCESS
    force_wait = 20;
    new_payload(2); rq_write[2] = 1'b0; rq_valid[2] = 1'b1;
    step();
    rq_valid[2] = 1'b0;
    repeat (3) step();
    chk("pre-reset penable", 64'(bus.penable_o), 64'h1);
    do_reset(2);
    force_wait = 0;
    for (int i = 0; i < N; i++) begin new_payload(i); rq_valid[i] = 1'b1; end
    step();
    chk("post-reset winner", 64'(obs_ready), 64'h1);
    rq_valid = '0;
    drain();

`ifdef APB_ARB_TIMEOUT_EN
    force_wait = 20;
    new_payload(3); rq_write[3] = 1'b0; rq_valid[3] = 1'b1;
    got = -1; e = 1'b0; d = '1;
    for (int c = 0; c < 20 && got < 0; c++) begin
      step();
      if (c == 0) rq_valid[3] = 1'b0;
      if (obs_rsp[3]) begin got = c; e = obs_err; d = obs_rdata; end
    end
    chk("timeout rsp cycle", 64'(got), 64'(2 + TO));
    chk("timeout err",       64'(e),   64'h1);
    chk("timeout rdata",     64'(d),   64'h0);
    force_wait = 0;
    new_payload(1); rq_valid[1] = 1'b1;
    step();
    chk("timeout back idle", 64'(obs_ready), 64'h2);
    rq_valid = '0;
    drain();
`else
    got = 0; e = 1'b0; d = '0;
`endif

    // random traffic
    force_wait = -1;
    for (int c = 0; c < 1500; c++) begin
      req_update(1'b0);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached at cycle %0d", t);
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Round-robin APB requester arbiter and master sequencer. It shares one APB completer (typically `apb_mem`) between `NumReq` independent requesters. Each requester posts a single-beat read or write on a valid/ready request channel. The block grants one requester at a time, runs a full APB SETUP/ACCESS transfer and returns the read data on a per-requester response pulse.

## Interface
- `NumReq`, default 2: number of requesters, at least 2.
- `AddrWidth`, default 8: APB address width.
- `DataWidth`, default 32: APB data width.
- `TimeoutCycles`, default 16: maximum ACCESS cycles before abort. Used only when `APB_ARB_TIMEOUT_EN` is defined; must be at least 1.
- `clk_i` input 1: clock; all logic on the rising edge.
- `arst_ni` input 1: reset, asynchronous, active-low.
- `req_valid_i` input NumReq: request pending, one bit per requester.
- `req_ready_o` output NumReq: one-hot grant; the request is accepted in the cycle this bit is high.
- `req_addr_i` input NumReq*AddrWidth: packed addresses; requester i occupies bits [i*AddrWidth +: AddrWidth].
- `req_write_i` input NumReq: 1 = write, 0 = read.
- `req_wdata_i` input NumReq*DataWidth: packed write data, same slicing as `req_addr_i`.
- `rsp_valid_o` output NumReq: one-cycle completion pulse, one-hot.
- `rsp_rdata_o` output DataWidth: read data; valid while any `rsp_valid_o` bit is high.
- `rsp_err_o` output 1: transfer aborted by timeout; valid with `rsp_valid_o`.
- `psel_o` output 1: APB select.
- `penable_o` output 1: APB enable.
- `paddr_o` output AddrWidth: APB address.
- `pwrite_o` output 1: APB write.
- `pwdata_o` output DataWidth: APB write data.
- `prdata_i` input DataWidth: APB read data.
- `pready_i` input 1: APB ready. X or Z is treated as 0 only while `penable_o` is 0.

## Operation
- FSM has three states: IDLE, SETUP, ACCESS.
- **IDLE:**
  - If any `req_valid_i` bit is set, pick the winner by round-robin.
  - Search starts at index (`last_grant` + 1) mod `NumReq` and wraps.
  - Drive `req_ready_o` one-hot to the winner (combinational, IDLE only).
  - Capture the winner's addr, write and wdata into holding registers.
  - Update `last_grant` to the winner; go to SETUP.
  - If no bit is set, stay in IDLE and drive `req_ready_o` = 0.
- **SETUP:** `psel_o` = 1, `penable_o` = 0. Go to ACCESS unconditionally.
- **ACCESS:**
  - `psel_o` = 1, `penable_o` = 1.
  - On `pready_i` = 1, register `prdata_i` (reads only; writes return 0), pulse `rsp_valid_o[last_grant]` next cycle and go to IDLE.
  - Otherwise hold in ACCESS.
- `paddr_o`, `pwrite_o` and `pwdata_o` come from the holding registers. They are stable from SETUP through the completing ACCESS cycle and unchanged in IDLE.
- A requester must hold `req_valid_i` and its payload stable until its `req_ready_o` bit is seen. Dropping valid before grant is legal; that requester is simply skipped.
- Exactly one transfer is outstanding at any time. Requests arriving during SETUP/ACCESS wait; `req_ready_o` stays 0.

## Timing
- Reset values:
  - State IDLE, `last_grant` = `NumReq`-1, so requester 0 wins first after reset.
  - All outputs 0: `psel_o`, `penable_o`, `paddr_o`, `pwrite_o`, `pwdata_o`, `req_ready_o`, `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`.
- Latency with zero wait states:
  - Grant at cycle 0 (IDLE), SETUP at cycle 1, ACCESS with `pready_i` at cycle 2.
  - `rsp_valid_o` at cycle 3, coinciding with IDLE, where the next grant may occur.
  - Throughput is one transfer per 3 cycles.
- Each wait state (ACCESS with `pready_i` = 0) adds one cycle.
- `rsp_valid_o` and `rsp_rdata_o` are registered. `rsp_rdata_o` holds its last value between pulses.
- Round-robin grant sequences:
  - With all requesters continuously valid: 0, 1, …, `NumReq`-1, 0, …
  - A single persistent requester is granted every transfer.
- Reset asserted mid-transfer: all outputs drop to reset values immediately (asynchronous). The in-flight transfer is discarded with no `rsp_valid_o`; requesters must re-issue.

## Configuration
- Macro: `APB_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter, cleared on SETUP, increments on each ACCESS cycle with `pready_i` = 0.
  - When it reaches `TimeoutCycles`, the transfer ends: `rsp_valid_o` pulses with `rsp_err_o` = 1 and `rsp_rdata_o` = 0.
  - The FSM returns to IDLE and `psel_o`/`penable_o` deassert.
  - Counter width is $clog2(`TimeoutCycles`+1).
- **Undefined:** no counter. ACCESS waits on `pready_i` indefinitely and `rsp_err_o` is tied to 0.

## Test plan
- **Single write/read:** Reset, then requester 0 writes 0xA5A5_0001 to addr 0x10, then reads 0x10 with `pready_i` = 1.
  - Required: `req_ready_o` = 01 at cycle 0, `psel_o` at cycles 1–2, `penable_o` at cycle 2.
  - Required: `rsp_valid_o` = 01 at cycle 3; the read returns 0xA5A5_0001.
- **Round-robin fairness:** `NumReq` = 4, all valid continuously for 8 transfers.
  - Required: grant order 0,1,2,3,0,1,2,3; no `req_ready_o` outside IDLE.
- **Wait states:** hold `pready_i` = 0 for 3 ACCESS cycles.
  - Required: `paddr_o`/`pwdata_o` stable throughout; `rsp_valid_o` 4 cycles after ACCESS entry; `rsp_err_o` = 0.
- **Simultaneous request and completion:** requester 1 raises valid in the cycle requester 0's ACCESS completes.
  - Required: requester 1 is granted in the next IDLE cycle, the same cycle as requester 0's `rsp_valid_o`.
- **Reset during ACCESS:** assert `arst_ni` = 0 with `pready_i` held at 0.
  - Required: `psel_o` = `penable_o` = 0 immediately; no `rsp_valid_o`; requester 0 wins first after reset.
- **Timeout** (`APB_ARB_TIMEOUT_EN`, `TimeoutCycles` = 4): `pready_i` held at 0.
  - Required: after 4 ACCESS cycles, `rsp_valid_o` pulses with `rsp_err_o` = 1 and `rsp_rdata_o` = 0, and the FSM is back in IDLE.
